// File: rtl/byte_packer_pkg.sv
// Shared widths, types and the byte-enable helper for the byte packer.
package byte_packer_pkg;

    localparam int DATA_W = 8;
    localparam int BYTES  = 4;
    localparam int WORD_W = DATA_W * BYTES;
    localparam int CNT_W  = $clog2(BYTES);

    typedef logic [CNT_W-1:0] lane_cnt_t;
    typedef logic [BYTES-1:0] keep_t;

    // Lanes 0..cnt enabled, equivalent to (1 << (cnt+1)) - 1.
    function automatic keep_t keep_mask(input lane_cnt_t cnt);
        keep_t mask;
        for (int i = 0; i < BYTES; i++) begin
            mask[i] = (i <= int'(cnt));
        end
        return mask;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register: loads a finished word, holds it under backpressure,
// and retires it when the downstream stage accepts.
module pack_out_reg #(
    parameter int WORD_W = byte_packer_pkg::WORD_W,
    parameter int BYTES  = byte_packer_pkg::BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [BYTES-1:0]  keep_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic [BYTES-1:0]  keep_o,
    output logic              last_o
);
    import byte_packer_pkg::*;

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [BYTES-1:0]  keep_q, keep_d;
    logic              last_q, last_d;

    // A load only arrives when the register is empty or being drained this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/byte_packer.sv
// Packs consecutive bytes little-endian into a wide word; last_i closes a
// packet early and the byte-enable mask marks the filled lanes.
module byte_packer #(
    parameter int DATA_W = byte_packer_pkg::DATA_W,
    parameter int BYTES  = byte_packer_pkg::BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [DATA_W*BYTES-1:0] data_o,
    output logic [BYTES-1:0]        keep_o,
    output logic                    last_o,
    output logic                    valid_o,
    input  logic                    ready_i
);
    import byte_packer_pkg::*;

    localparam lane_cnt_t LastLane = lane_cnt_t'(BYTES - 1);

    lane_cnt_t               cnt_q, cnt_d;
    logic [DATA_W*BYTES-1:0] acc_q, acc_d;
    logic [DATA_W*BYTES-1:0] mergedWord;
    keep_t                   wordKeep;
    logic                    inFire;
    logic                    wordDone;

    // Combinational path from ready_i keeps a full-rate stream bubble-free.
    assign ready_o  = !valid_o || ready_i;
    assign inFire   = valid_i && ready_o;
    assign wordDone = inFire && (last_i || (cnt_q == LastLane));
    assign wordKeep = keep_mask(cnt_q);

    // Lanes above cnt are always zero because the accumulator clears on completion.
    always_comb begin
        mergedWord = acc_q;
        mergedWord[int'(cnt_q)*DATA_W +: DATA_W] = data_i;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (wordDone) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (inFire) begin
            acc_d = mergedWord;
            cnt_d = cnt_q + lane_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    pack_out_reg #(
        .WORD_W(DATA_W*BYTES),
        .BYTES (BYTES)
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .load_i (wordDone),
        .data_i (mergedWord),
        .keep_i (wordKeep),
        .last_i (last_i),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .data_o (data_o),
        .keep_o (keep_o),
        .last_o (last_o)
    );

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: a queue-based packet model checked every
// cycle, plus hand-computed word literals that pin the model.
module tb_byte_packer;

    localparam int BYTES = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } wordT;

    logic        clk;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic [3:0]  keep_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] pend[$];
    wordT       expQ[$];
    wordT       modelLog[$];

    byte_packer dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .valid_i(valid_i),
        .last_i (last_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .keep_o (keep_o),
        .last_o (last_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes collect in a queue; a word forms at BYTES bytes or on last_i.
    always @(negedge clk) begin
        logic expValid;
        wordT w;
        if (rst) begin
            check("rstValid", {31'd0, valid_o}, 32'd0);
            check("rstReady", {31'd0, ready_o}, 32'd1);
            pend.delete();
            expQ.delete();
        end else begin
            expValid = (expQ.size() != 0);
            check("valid", {31'd0, valid_o}, {31'd0, expValid});
            check("ready", {31'd0, ready_o}, {31'd0, (!expValid || ready_i)});
            if (expValid) begin
                check("data", data_o, expQ[0].data);
                check("keep", {28'd0, keep_o}, {28'd0, expQ[0].keep});
                check("last", {31'd0, last_o}, {31'd0, expQ[0].last});
                if (ready_i) void'(expQ.pop_front());
            end
            if (valid_i && (!expValid || ready_i)) begin
                pend.push_back(data_i);
                if (pend.size() == BYTES || last_i) begin
                    w.data = '0;
                    for (int i = 0; i < pend.size(); i++) w.data[i*8 +: 8] = pend[i];
                    w.keep = 4'((1 << pend.size()) - 1);
                    w.last = last_i;
                    expQ.push_back(w);
                    modelLog.push_back(w);
                    pend.delete();
                end
            end
        end
    end

    // Offers one byte and holds it until the DUT takes it; returns at posedge+1.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int   guard;
        logic took;
        guard   = 0;
        took    = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!took && guard < 200) begin
            @(negedge clk);
            took = ready_o;
            @(posedge clk);
            #1;
            guard++;
        end
        valid_i = 1'b0;
        data_i  = 8'hEE;
        last_i  = 1'b1;
        if (!took) check("handshakeTimeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
        if (idx < modelLog.size()) begin
            check($sformatf("word%0d data", idx), modelLog[idx].data, d);
            check($sformatf("word%0d keep", idx), {28'd0, modelLog[idx].keep}, {28'd0, k});
            check($sformatf("word%0d last", idx), {31'd0, modelLog[idx].last}, {31'd0, l});
        end else begin
            check($sformatf("word%0d present", idx), modelLog.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        last_i  = 1'b0;
        ready_i = 1'b1;

        @(negedge clk);
        check("resetData",  data_o,             32'h0);
        check("resetKeep",  {28'd0, keep_o},    32'h0);
        check("resetLast",  {31'd0, last_o},    32'h0);
        check("resetValid", {31'd0, valid_o},   32'h0);
        check("resetReady", {31'd0, ready_o},   32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full word, with latency and single-cycle valid pinned literally.
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        @(negedge clk);
        check("fullValidRise", {31'd0, valid_o}, 32'h1);
        check("fullData",      data_o,           32'h44332211);
        check("fullKeep",      {28'd0, keep_o},  32'hF);
        @(negedge clk);
        check("fullValidFall", {31'd0, valid_o}, 32'h0);
        idle(1);
        checkOutput(0, 32'h44332211, 4'hF, 1'b0);

        // Short packet and single-byte packet.
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b1);
        idle(2);
        checkOutput(1, 32'h0000BBAA, 4'h3, 1'b1);
        applyStimulus(8'h5C, 1'b1);
        idle(2);
        checkOutput(2, 32'h0000005C, 4'h1, 1'b1);

        // Backpressure: word held while the next byte waits.
        ready_i = 1'b0;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        fork
            begin
                applyStimulus(8'h01, 1'b0);
                applyStimulus(8'h02, 1'b0);
                applyStimulus(8'h03, 1'b0);
                applyStimulus(8'h04, 1'b0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bpReadyLow", {31'd0, ready_o}, 32'h0);
                    check("bpDataHeld", data_o, 32'h44332211);
                end
                @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        idle(3);
        checkOutput(3, 32'h44332211, 4'hF, 1'b0);
        checkOutput(4, 32'h04030201, 4'hF, 1'b0);

        // Back-to-back stream.
        for (int b = 8'h10; b <= 8'h17; b++) applyStimulus(8'(b), 1'b0);
        idle(2);
        checkOutput(5, 32'h13121110, 4'hF, 1'b0);
        checkOutput(6, 32'h17161514, 4'hF, 1'b0);

        // Gap mid-word, then last_i on the final lane.
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        idle(5);
        applyStimulus(8'hA3, 1'b0);
        applyStimulus(8'hA4, 1'b1);
        idle(2);
        checkOutput(7, 32'hA4A3A2A1, 4'hF, 1'b1);

        // Three-byte packet.
        applyStimulus(8'hC1, 1'b0);
        applyStimulus(8'hC2, 1'b0);
        applyStimulus(8'hC3, 1'b1);
        idle(2);
        checkOutput(8, 32'h00C3C2C1, 4'h7, 1'b1);

        // Reset mid-word discards the partial word.
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h66, 1'b0);
        idle(3);
        checkOutput(9, 32'h66554433, 4'hF, 1'b0);

        idle(3);
        check("finalValid", {31'd0, valid_o}, 32'h0);
        check("wordCount",  modelLog.size(), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
